// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_port peripheral.
//   uart_op_e  : core operation codes on the UART select bus
//   tx/rx state enums for the serial engines
//   ST_*       : bit positions inside the status read word
package uart_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        UOP_STATUS = 2'd0,
        UOP_TX     = 2'd1,
        UOP_RX     = 2'd2,
        UOP_CLR    = 2'd3
    } uart_op_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam int unsigned ST_TX_BUSY      = 0;
    localparam int unsigned ST_TX_FULL      = 1;
    localparam int unsigned ST_RX_EMPTY     = 2;
    localparam int unsigned ST_RX_OVERRUN   = 3;
    localparam int unsigned ST_RX_FRAME_ERR = 4;
    localparam int unsigned ST_TX_DROP      = 5;
    localparam int unsigned ST_RX_COUNT_LSB = 8;
    localparam int unsigned ST_RX_COUNT_W   = 4;

endpackage

// File: rtl/uart_port_if.sv
// Core-side access bus of the UART peripheral.
//   uart_op  : operation code, valid for one cycle per access
//   data_in  : store data from the core (byte in [7:0])
//   data_out : read word returned in the same cycle
// master = CPU core, slave = uart_port.
interface uart_port_if;
    import uart_pkg::*;

    uart_op_e           uart_op;
    logic [WORD_W-1:0]  data_in;
    logic [WORD_W-1:0]  data_out;

    modport master (output uart_op, output data_in, input data_out);
    modport slave  (input uart_op, input data_in, output data_out);

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head output.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write request and data
//   pop      : read request (ignored when empty)
//   flush    : empties the FIFO; wins over push and pop
//   dout     : current head entry
//   full, empty, count : occupancy
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_port.sv
// Memory-mapped 8N1 UART with TX and RX FIFOs.
//   clk, rst : clock, synchronous active-high reset
//   bus      : core access (op code, store data, same-cycle read word)
//   rx       : asynchronous serial input
//   tx       : serial output, idles high
module uart_port
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned TX_DEPTH     = 4,
    parameter int unsigned RX_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    uart_port_if.slave  bus,
    input  logic        rx,
    output logic        tx
);

    localparam int unsigned BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned BAUD_LAST = CLKS_PER_BIT - 1;
    localparam int unsigned HALF_LAST = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned TX_CW     = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_CW     = $clog2(RX_DEPTH) + 1;

    // Op decode
    logic op_tx;
    logic op_rx;
    logic op_clr;
    assign op_tx  = (bus.uart_op == UOP_TX);
    assign op_rx  = (bus.uart_op == UOP_RX);
    assign op_clr = (bus.uart_op == UOP_CLR);

    // Only the low byte of store data is meaningful.
    logic data_hi_unused;
    assign data_hi_unused = ^bus.data_in[WORD_W-1:BYTE_W];

    // ---------------- TX side ----------------
    tx_state_e          tx_state;
    logic [BAUD_W-1:0]  tx_cnt;
    logic [2:0]         tx_bit;
    logic [BYTE_W-1:0]  tx_shift;
    logic [BYTE_W-1:0]  tx_head;
    logic               tx_full;
    logic               tx_empty;
    logic [TX_CW-1:0]   tx_count_unused;
    logic               tx_bit_end;
    logic               tx_pop;

    assign tx_bit_end = (tx_cnt == BAUD_W'(BAUD_LAST));
    // A new frame is loaded from IDLE, or back-to-back at the end of STOP.
    assign tx_pop = !tx_empty &&
                    ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end));

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (op_tx),
        .pop   (tx_pop),
        .flush (1'b0),
        .din   (bus.data_in[BYTE_W-1:0]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count_unused)
    );

    // TX serializer: start bit, 8 data bits LSB first, stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            unique case (tx_state)
                TX_IDLE: begin
                    tx <= 1'b1;
                    if (tx_pop) begin
                        tx_state <= TX_START;
                        tx_shift <= tx_head;
                        tx_cnt   <= '0;
                        tx       <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_state <= TX_DATA;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx       <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[BYTE_W-1:1]};
                    end else begin
                        tx_cnt <= tx_cnt + BAUD_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            tx       <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx       <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[BYTE_W-1:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + BAUD_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_pop) begin
                            tx_state <= TX_START;
                            tx_shift <= tx_head;
                            tx       <= 1'b0;
                        end else begin
                            tx_state <= TX_IDLE;
                            tx       <= 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- RX side ----------------
    rx_state_e          rx_state;
    logic               rx_s1;
    logic               rx_s2;
    logic               rx_prev;
    logic [BAUD_W-1:0]  rx_cnt;
    logic [2:0]         rx_bit;
    logic [BYTE_W-1:0]  rx_shift;
    logic [BYTE_W-1:0]  rx_head;
    logic               rx_full;
    logic               rx_empty;
    logic [RX_CW-1:0]   rx_count;
    logic               rx_bit_end;
    logic               rx_done_ok;
    logic               rx_done_bad;

    assign rx_bit_end  = (rx_cnt == BAUD_W'(BAUD_LAST));
    assign rx_done_ok  = (rx_state == RX_STOP) && rx_bit_end && rx_s2;
    assign rx_done_bad = (rx_state == RX_STOP) && rx_bit_end && !rx_s2;

    sync_fifo #(.WIDTH(BYTE_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_done_ok && !op_clr),
        .pop   (op_rx),
        .flush (op_clr),
        .din   (rx_shift),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // RX deserializer behind a 2-flop synchronizer; samples at bit centres.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            unique case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Half a bit in: a line back high means it was a glitch.
                    if (rx_cnt == BAUD_W'(HALF_LAST)) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + BAUD_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[BYTE_W-1:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + BAUD_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + BAUD_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- sticky flags ----------------
    logic rx_overrun;
    logic rx_frame_err;
    logic tx_drop;

    // Clear first so a same-cycle event still leaves its flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            tx_drop      <= 1'b0;
        end else begin
            if (op_clr) begin
                rx_overrun   <= 1'b0;
                rx_frame_err <= 1'b0;
                tx_drop      <= 1'b0;
            end
            if (rx_done_ok && rx_full && !op_rx && !op_clr) begin
                rx_overrun <= 1'b1;
            end
            if (rx_done_bad) begin
                rx_frame_err <= 1'b1;
            end
            if (op_tx && tx_full && !tx_pop) begin
                tx_drop <= 1'b1;
            end
        end
    end

    // ---------------- read word ----------------
    logic [WORD_W-1:0] status;

    always_comb begin
        status                                      = '0;
        status[ST_TX_BUSY]                          = (tx_state != TX_IDLE);
        status[ST_TX_FULL]                          = tx_full;
        status[ST_RX_EMPTY]                         = rx_empty;
        status[ST_RX_OVERRUN]                       = rx_overrun;
        status[ST_RX_FRAME_ERR]                     = rx_frame_err;
        status[ST_TX_DROP]                          = tx_drop;
        status[ST_RX_COUNT_LSB +: ST_RX_COUNT_W]    = ST_RX_COUNT_W'(rx_count);
    end

    always_comb begin
        bus.data_out = '0;
        unique case (bus.uart_op)
            UOP_STATUS: bus.data_out = status;
            UOP_RX: begin
                if (!rx_empty) begin
                    bus.data_out = WORD_W'({1'b1, rx_head});
                end
            end
            default: bus.data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_port.sv
// Self-checking bench for uart_port: directed cases plus randomized TX bursts
// and RX frame sessions, checked against a queue-based model of the peripheral.
module tb_uart_port;
    import uart_pkg::*;

    localparam int C   = 4;
    localparam int TXD = 4;
    localparam int RXD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;
    int   cyc = 0;

    uart_port_if bus();

    uart_port #(.CLKS_PER_BIT(C), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .rx  (rx),
        .tx  (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // RX model: bytes expected in the FIFO and sticky flags.
    logic [7:0] rxq[$];
    bit         m_ov = 0;
    bit         m_fe = 0;

    // TX line monitor results.
    logic [7:0] mon_byte[$];
    logic       mon_stop[$];
    int         mon_start[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_op(input uart_op_e op, input logic [31:0] d, output logic [31:0] r);
        bus.uart_op = op;
        bus.data_in = d;
        @(negedge clk);
        r = bus.data_out;
        tick(1);
        bus.uart_op = UOP_STATUS;
        bus.data_in = '0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(C);
        end
        rx = stop;
        tick(C);
        rx = 1'b1;
        tick(2 * C);
    endtask

    function automatic logic [31:0] exp_status(input bit busy, input bit full, input bit drop);
        logic [31:0] s;
        s = '0;
        s[0]    = busy;
        s[1]    = full;
        s[2]    = (rxq.size() == 0);
        s[3]    = m_ov;
        s[4]    = m_fe;
        s[5]    = drop;
        s[11:8] = 4'(rxq.size());
        return s;
    endfunction

    task automatic model_clear();
        rxq.delete();
        m_ov = 0;
        m_fe = 0;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] r;
        logic [31:0] e;
        e = '0;
        if (rxq.size() > 0) e = {23'b0, 1'b1, rxq.pop_front()};
        do_op(UOP_RX, 32'h0, r);
        check_eq(tag, r, e);
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        tick(2);
        while (bus.data_out[0] !== 1'b0 && n < 2000) begin
            tick(1);
            n++;
        end
        if (n >= 2000) begin
            n_vec++;
            n_err++;
            $display("FAIL tx_idle_timeout: got busy after %0d cycles, required idle", n);
        end
        tick(2);
    endtask

    // Randomized frames on rx with optional bad stop bits and interleaved pops.
    task automatic rx_session(input int nf, input bit with_err, input bit with_pops);
        logic [7:0] b;
        bit         bad;
        for (int f = 0; f < nf; f++) begin
            b   = 8'($urandom);
            bad = with_err && ($urandom_range(0, 5) == 0);
            send_rx(b, !bad);
            if (bad)                    m_fe = 1;
            else if (rxq.size() == RXD) m_ov = 1;
            else                        rxq.push_back(b);
            if (with_pops) repeat ($urandom_range(0, 2)) pop_check("rx_pop_mid");
        end
    endtask

    // k back-to-back writes into an idle transmitter: the first is taken by the
    // FSM one cycle later, so TXD+1 bytes fit and any beyond that are dropped.
    task automatic tx_burst(input int k);
        logic [7:0]  bytes[$];
        logic [7:0]  b;
        logic [31:0] r;
        logic [31:0] junk;
        int          acc;
        int          c0;
        do_op(UOP_CLR, 32'h0, r);
        check_eq("clr_rd", r, 32'h0);
        model_clear();
        wait_tx_idle();
        mon_byte.delete();
        mon_stop.delete();
        mon_start.delete();
        c0 = cyc;
        for (int i = 0; i < k; i++) begin
            b    = 8'($urandom);
            junk = $urandom;
            bytes.push_back(b);
            do_op(UOP_TX, {junk[31:8], b}, r);
            check_eq("tx_wr_rd", r, 32'h0);
        end
        acc = (k < TXD + 1) ? k : TXD + 1;
        tick(1);
        do_op(UOP_STATUS, 32'h0, r);
        check_eq("tx_burst_status", r, exp_status(1, (acc - 1) == TXD, k > TXD + 1));
        wait_tx_idle();
        check_eq("tx_nframes", 32'(mon_byte.size()), 32'(acc));
        if (mon_start.size() > 0) check_eq("tx_first_start", 32'(mon_start[0]), 32'(c0 + 2));
        for (int i = 0; i < acc && i < mon_byte.size(); i++) begin
            check_eq("tx_byte", 32'(mon_byte[i]), 32'(bytes[i]));
            check_eq("tx_stop", 32'(mon_stop[i]), 32'd1);
            if (i > 0) check_eq("tx_gap", 32'(mon_start[i] - mon_start[i-1]), 32'(10 * C));
        end
    endtask

    // TX line monitor: decodes each frame at its bit centres.
    initial begin
        logic [7:0] mb;
        int         ms;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                ms = cyc;
                repeat (C + C / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    mb[i] = tx;
                    repeat (C) @(negedge clk);
                end
                mon_byte.push_back(mb);
                mon_stop.push_back(tx);
                mon_start.push_back(ms);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required $finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  a5;
        logic        e;

        bus.uart_op = UOP_STATUS;
        bus.data_in = '0;
        rx  = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        do_op(UOP_STATUS, 32'h0, r);
        check_eq("reset_status", r, 32'h0000_0004);
        check_eq("reset_tx", 32'(tx), 32'd1);

        // Single byte 0xA5: exact waveform and busy window
        a5 = 8'hA5;
        mon_byte.delete();
        mon_start.delete();
        mon_stop.delete();
        do_op(UOP_TX, 32'h0000_00A5, r);
        check_eq("a5_wr_rd", r, 32'h0);
        check_eq("a5_tx_pre", 32'(tx), 32'd1);
        tick(1);
        for (int k = 0; k < 10 * C; k++) begin
            if (k < C)          e = 1'b0;
            else if (k < 9 * C) e = a5[3'((k - C) / C)];
            else                e = 1'b1;
            check_eq("a5_tx_bit", 32'(tx), 32'(e));
            check_eq("a5_busy", 32'(bus.data_out[0]), 32'd1);
            tick(1);
        end
        check_eq("a5_busy_end", 32'(bus.data_out[0]), 32'd0);
        check_eq("a5_tx_end", 32'(tx), 32'd1);
        check_eq("a5_mon", (mon_byte.size() > 0) ? 32'(mon_byte[0]) : 32'hFFFF_FFFF, 32'h0000_00A5);

        // Reset in mid-frame on both directions
        do_op(UOP_TX, 32'h0, r);
        rx = 1'b0;
        tick(12);
        rst = 1'b1;
        tick(1);
        check_eq("rst_abort_tx", 32'(tx), 32'd1);
        rst = 1'b0;
        rx  = 1'b1;
        tick(1);
        do_op(UOP_STATUS, 32'h0, r);
        check_eq("rst_abort_status", r, 32'h0000_0004);
        tick(60);

        // RX of 0x3C, then pop on empty
        model_clear();
        send_rx(8'h3C, 1'b1);
        do_op(UOP_RX, 32'h0, r);
        check_eq("rx_3c", r, 32'h0000_013C);
        do_op(UOP_RX, 32'h0, r);
        check_eq("rx_3c_empty", r, 32'h0);
        do_op(UOP_STATUS, 32'h0, r);
        check_eq("rx_3c_status", r, 32'h0000_0004);

        // Nine frames without pops: overrun, count 8, FIFO order, clear
        rx_session(9, 0, 0);
        do_op(UOP_STATUS, 32'h0, r);
        check_eq("ovr_status", r, 32'h0000_0808);
        for (int i = 0; i < RXD + 1; i++) pop_check("ovr_pop");
        do_op(UOP_STATUS, 32'h0, r);
        check_eq("ovr_drained", r, 32'h0000_000C);
        do_op(UOP_CLR, 32'h0, r);
        check_eq("ovr_clr_rd", r, 32'h0);
        model_clear();
        do_op(UOP_STATUS, 32'h0, r);
        check_eq("ovr_cleared", r, 32'h0000_0004);

        // Framing error, then a one-cycle glitch
        send_rx(8'h55, 1'b0);
        do_op(UOP_STATUS, 32'h0, r);
        check_eq("ferr_status", r, 32'h0000_0014);
        do_op(UOP_CLR, 32'h0, r);
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(3 * C);
        do_op(UOP_STATUS, 32'h0, r);
        check_eq("glitch_status", r, 32'h0000_0004);

        // Five writes fit (one taken, four queued); the sixth is dropped
        tx_burst(5);
        tx_burst(6);

        // Randomized mix
        for (int it = 0; it < 6; it++) begin
            tx_burst($urandom_range(1, 6));
            do_op(UOP_CLR, 32'h0, r);
            model_clear();
            rx_session($urandom_range(1, 10), 1, 1);
            do_op(UOP_STATUS, 32'h0, r);
            check_eq("rnd_rx_status", r, exp_status(0, 0, 0));
            for (int i = rxq.size(); i >= 0; i--) pop_check("rnd_rx_drain");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
